seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Downstream consumer of the 4-digit BCD counter. Takes four 4-bit BCD digits and drives a time-multiplexed, common-anode 4-digit seven-segment display.
- Contains a refresh prescaler, a rotating digit selector, a per-frame shadow snapshot of the digits (no tearing mid-frame) and a BCD-to-segment decoder.
- All outputs are registered and go straight to board pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz per frame); legal range >= 2.
- CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- en  in  1  display enable, active-high; 0 turns all anodes off and does not stop scanning.
- bcd_digit0  in  4  ones digit from the BCD counter.
- bcd_digit1  in  4  tens digit.
- bcd_digit2  in  4  hundreds digit.
- bcd_digit3  in  4  thousands digit.
- dp_in  in  4  per-digit decimal point request, active-high; bit i goes with digit i.
- an  out  4  anode enables, active-low; an[i] drives digit i.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point cathode, active-low.

Behaviour:
- Reset (rst=0 at an edge):
  - cnt=0, sel=0, shadow digits=0, shadow dp=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Reset mid-frame aborts the scan immediately. After release, scanning starts at digit0 showing the shadow value 0 until the first snapshot.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (cnt==REFRESH_DIV-1), one cycle wide.
- Selector:
  - On tick, sel advances 0→1→2→3→0 (wrap 3→0).
  - sel holds when tick=0.
- Snapshot:
  - On the edge where tick=1 and sel==3, capture bcd_digit0..3 and dp_in into the shadow registers, together with the sel wrap to 0.
  - Input changes at any other time have no visible effect until the next frame.
- Output stage:
  - an, seg and dp are registered from (sel, shadow, en). They lag sel by exactly 1 clk.
  - an = active-low one-hot of sel when en=1; 4'b1111 when en=0.
  - seg = decode(shadow[sel]).
  - dp = ~shadow_dp[sel].
  - When en=0, seg=7'b1111111 and dp=1.
- Decode table ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Invalid BCD (10–15): shows a dash (only g lit), seg=0111111. The dp request is still honoured.
- Simultaneous events:
  - rst=0 overrides everything.
  - en toggling takes effect on the next output register update (1 clk). It does not disturb cnt, sel or shadow.
- Frame period = 4*REFRESH_DIV clk. Each digit is lit for REFRESH_DIV consecutive clk.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - digit3 is blanked if shadow3==0.
  - digit2 is blanked if shadow3==0 and shadow2==0.
  - digit1 is blanked if shadow3..1 all 0.
  - digit0 is never blanked.
  - A blanked slot drives an=4'b1111, seg=7'b1111111, dp=1. Its time slot is preserved, so the frame period is unchanged.
  - An invalid digit (>9) counts as non-zero.
- Undefined: all four digits are always shown, leading zeros included. No blanking logic is synthesised.

Test Plan:
- REFRESH_DIV=4; hold rst=0 for 3 clk, then release -> during reset an=1111, seg=1111111, dp=1. First an=1110 appears 1 clk after release, showing seg=1000000 (shadow 0).
- REFRESH_DIV=4, digits 3,2,1,0 = 1,2,3,4, en=1, after first snapshot -> an sequence 1110/1101/1011/0111, each held 4 clk. seg: 0011001, 0110000, 0100100, 1111001.
- Change bcd_digit0 from 4 to 7 while sel==1 -> digit0 still shows 0011001 until the wrap to sel 0. The next frame shows 1111000.
- bcd_digit2=4'hC, dp_in=4'b0100 -> digit2 slot shows seg=0111111, dp=0. All other slots show dp=1.
- en=0 for 10 clk mid-frame -> an=1111 from 1 clk after the drop. When en returns to 1, sel shows it kept advancing (slot alignment unchanged).
- With LEADING_ZERO_BLANK_EN, digits 0,0,5,0 (3..0) -> slots 3 and 2 show an=1111. Slot 1 shows 0010010, slot 0 shows 1000000. With 0,0,0,0, only digit0 is lit.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: digit/enable inputs and display pin outputs of the
// four-digit seven-segment scanner. master = digit source, slave = scanner.
interface seven_seg_scanner_if;
  logic       en;
  logic [3:0] bcd_digit0;
  logic [3:0] bcd_digit1;
  logic [3:0] bcd_digit2;
  logic [3:0] bcd_digit3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output en, bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, dp_in,
    input  an, seg, dp
  );

  modport slave (
    input  en, bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, dp_in,
    output an, seg, dp
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode 4-digit display driver.
// A prescaler paces digit slots, a 2-bit selector rotates through digits,
// the digits are snapshotted once per frame so a frame never tears, and the
// selected digit is decoded into registered active-low pin outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit0
// is always shown); without it every digit is displayed.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_scanner_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel;
  logic [3:0]       shadow_digit [4];
  logic [3:0]       shadow_dp;
  logic             tick;

  logic [3:0]       cur_digit;
  logic             blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 becomes a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign tick = (cnt == CNT_LAST);

  // Prescaler: one tick every REFRESH_DIV clocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Digit selector: advance one slot per tick, wrapping 3 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel <= 2'd0;
    end else if (tick) begin
      sel <= sel + 2'd1;
    end
  end

  // Frame snapshot: latch all digits and dp requests as the scan wraps to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_digit[0] <= 4'd0;
      shadow_digit[1] <= 4'd0;
      shadow_digit[2] <= 4'd0;
      shadow_digit[3] <= 4'd0;
      shadow_dp       <= 4'd0;
    end else if (tick && sel == 2'd3) begin
      shadow_digit[0] <= bus.bcd_digit0;
      shadow_digit[1] <= bus.bcd_digit1;
      shadow_digit[2] <= bus.bcd_digit2;
      shadow_digit[3] <= bus.bcd_digit3;
      shadow_dp       <= bus.dp_in;
    end
  end

  assign cur_digit = shadow_digit[sel];

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero detect: a slot is blank when it and every higher digit are 0.
  always_comb begin
    blank = 1'b0;
    case (sel)
      2'd3:    blank = (shadow_digit[3] == 4'd0);
      2'd2:    blank = (shadow_digit[3] == 4'd0) && (shadow_digit[2] == 4'd0);
      2'd1:    blank = (shadow_digit[3] == 4'd0) && (shadow_digit[2] == 4'd0) &&
                       (shadow_digit[1] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Pin values for the current slot; disabled or blanked slots are dark.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    if (bus.en && !blank) begin
      an_next  = ~(4'b0001 << sel);
      seg_next = decode(cur_digit);
      dp_next  = ~shadow_dp[sel];
    end
  end

  // Output register: pins update one clock after sel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.an  <= 4'b1111;
      bus.seg <= 7'b1111111;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= an_next;
      bus.seg <= seg_next;
      bus.dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: self-checking bench for seven_seg_scanner with
// REFRESH_DIV=4. The reference model tracks elapsed clocks since reset and
// derives the displayed slot and frame snapshots arithmetically from that.
module tb_seven_seg_scanner;
  localparam int RD = 4;

  logic clk;
  logic rst;
  seven_seg_scanner_if bus();

  seven_seg_scanner #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model state
  int         k;            // clock edges since reset release
  logic [3:0] m_dig [4];
  logic [3:0] m_dp;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic model_edge();
    int  s;
    bit  blank;
    exp_an  = 4'b1111;
    exp_seg = 7'b1111111;
    exp_dp  = 1'b1;
    if (!rst) begin
      k = 0;
      for (int j = 0; j < 4; j++) m_dig[j] = 4'd0;
      m_dp = 4'd0;
      return;
    end
    k++;
    s = ((k - 1) / RD) % 4;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0) begin
      blank = 1'b1;
      for (int j = s; j < 4; j++) if (m_dig[j] != 4'd0) blank = 1'b0;
    end
`endif
    if (bus.en && !blank) begin
      exp_an  = ~(4'b0001 << s);
      exp_seg = seg_of(m_dig[s]);
      exp_dp  = ~m_dp[s];
    end
    if (k % (4 * RD) == 0) begin
      m_dig[0] = bus.bcd_digit0;
      m_dig[1] = bus.bcd_digit1;
      m_dig[2] = bus.bcd_digit2;
      m_dig[3] = bus.bcd_digit3;
      m_dp     = bus.dp_in;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0,
                            input logic [3:0] dpi);
    bus.bcd_digit3 = d3;
    bus.bcd_digit2 = d2;
    bus.bcd_digit1 = d1;
    bus.bcd_digit0 = d0;
    bus.dp_in      = dpi;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
        miscompares++;
        $display("FAIL reset_hold an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1",
                 bus.an, bus.seg, bus.dp);
      end
    end
    rst = 1'b1;
    cyc();
    vectors++;
    if ({bus.an, bus.seg, bus.dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_first_slot an=%b seg=%b dp=%b expected an=1110 seg=1000000 dp=1",
               bus.an, bus.seg, bus.dp);
    end
    $display("test_reset: done k=%0d", k);
  endtask

  task automatic test_scan(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cyc();
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("FAIL %s k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                 name, k, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
    $display("%s: %0d cycles scanned, k=%0d", name, cycles, k);
  endtask

  task automatic test_digits_1234();
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    test_scan("scan_1234", 40);
    // Spot check against the literal digit0 pattern after the first snapshot.
    while (((k / RD) % 4) != 0 || (k % RD) != 0) cyc();
    cyc();
    vectors++;
    if ({bus.an, bus.seg} !== {4'b1110, 7'b0011001}) begin
      miscompares++;
      $display("FAIL scan_digit0_literal an=%b seg=%b expected an=1110 seg=0011001",
               bus.an, bus.seg);
    end
  endtask

  task automatic test_snapshot();
    int guard;
    guard = 0;
    while (((k / RD) % 4) != 1 && guard < 16) begin
      cyc();
      guard++;
    end
    bus.bcd_digit0 = 4'd7;
    $display("test_snapshot: digit0 -> 7 at k=%0d", k);
    test_scan("snapshot", 36);
  endtask

  task automatic test_invalid_dp();
    set_digits(4'd1, 4'hC, 4'd3, 4'd7, 4'b0100);
    test_scan("invalid_dp", 40);
  endtask

  task automatic test_enable();
    test_scan("pre_disable", 6);
    bus.en = 1'b0;
    test_scan("disabled", 10);
    bus.en = 1'b1;
    test_scan("reenabled", 20);
  endtask

  task automatic test_blank();
    set_digits(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000);
    test_scan("blank_0050", 36);
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    test_scan("blank_0000", 36);
    set_digits(4'd0, 4'hA, 4'd0, 4'd0, 4'b1111);
    test_scan("blank_0A00", 36);
  endtask

  task automatic test_random();
    int hold;
    for (int t = 0; t < 60; t++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) bus.bcd_digit3 = 4'd0;
      bus.en = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 19) != 0);
      hold = $urandom_range(1, 20);
      $display("random %0d: digits=%h%h%h%h dp_in=%b en=%b rst=%b hold=%0d",
               t, bus.bcd_digit3, bus.bcd_digit2, bus.bcd_digit1, bus.bcd_digit0,
               bus.dp_in, bus.en, rst, hold);
      for (int i = 0; i < hold; i++) begin
        cyc();
        rst = 1'b1;
        vectors++;
        if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
          miscompares++;
          $display("FAIL random k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   k, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    k           = 0;
    m_dp        = 4'd0;
    for (int j = 0; j < 4; j++) m_dig[j] = 4'd0;
    rst    = 1'b0;
    bus.en = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);

    test_reset();
    test_digits_1234();
    test_snapshot();
    test_invalid_dp();
    test_enable();
    test_blank();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
